cp0_regfile: RTL and testbench
==============================

// Module: cp0_regfile
// PURPOSE
//   Coprocessor-0 register file at the receiving end of the write-back-to-CP0 bus. Holds the
//   BadVAddr, Count, Compare, Status, Cause and EPC registers (sel 0 only).
//   Records exceptions, eret and mtc0 arriving from WB, and returns mfc0 read data to WB.
//   Generates the timer interrupt and the pending-interrupt flag that WB/ID use to raise an exception.
// PARAMETERS
//   EX_ENTRY   32'hBFC0_0380  exception handler PC driven on ex_entry_pc
// PORTS
//   clk              in   1    clock
//   reset            in   1    synchronous, active-high reset
//   wb_to_cp0_bus    in   110  [109] ex, [108:104] excode, [103:72] badvaddr, [71] bd, [70:39] pc,
//                                [38] mtc0_we, [37:33] addr, [32:1] wdata, [0] eret
//   ext_int_in       in   6    hardware interrupt lines, level-sensitive
//   cp0_rdata        out  32   combinational read of register selected by bus addr
//   cp0_epc          out  32   current EPC (eret target)
//   ex_entry_pc      out  32   constant EX_ENTRY
//   cp0_has_int      out  1    interrupt pending and enabled
// BEHAVIOUR
//   Register map (addr): 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC.
//     Other addresses read 0; writes to them are ignored.
//   Reset values: Status=32'h0040_0000, Cause=0, EPC=0, BadVAddr=0, Count=0, Compare=0, tick=0.
//     Outputs follow from these values; cp0_has_int=0.
//   Status: BEV[22] read-only 1; IM[15:8], EXL[1], IE[0] writable; other bits read 0.
//   Cause: BD[31] and TI[30] read-only; IP[15:10] hardware; IP[9:8] writable;
//     ExcCode[6:2] read-only; other bits read 0.
//   All updates take effect on the clk edge. cp0_rdata is combinational on current state:
//     no write-through bypass. A same-cycle mtc0 becomes visible on the next cycle.
//   Priority in one cycle: ex > eret > mtc0. When ex=1, the eret and mtc0_we bits are ignored.
//   Exception (ex=1):
//     - Status.EXL<=1. Cause.ExcCode<=excode.
//     - If Status.EXL was 0: EPC<=bd ? pc-32'd4 : pc, and Cause.BD<=bd.
//     - If Status.EXL was 1: EPC and BD are unchanged.
//     - If excode==5'h04 (AdEL) or 5'h05 (AdES): BadVAddr<=badvaddr.
//   eret (ex=0, eret=1): Status.EXL<=0. No other change.
//   mtc0 (ex=0, eret=0, mtc0_we=1): write wdata into the masked writable bits of addr.
//     - Compare write also clears Cause.TI.
//     - Count write loads Count<=wdata and clears tick.
//   Count: 1-bit tick toggles every cycle. Count<=Count+1 on cycles where tick==1
//     (one increment per 2 clocks), wrapping 32'hFFFF_FFFF->0. No increment in a cycle
//     where mtc0 writes Count.
//   Timer: Cause.TI<=1 when Count==Compare. Stays set until a Compare write clears it.
//     A same-cycle Compare write wins (TI ends the cycle 0).
//   Cause.IP[15:10]<=ext_int_in every cycle, except IP[15]<=ext_int_in[5] | Cause.TI.
//     IP[15:10] is not writable by mtc0.
//   cp0_has_int = |(Cause.IP[15:8] & Status.IM[15:8]) & Status.IE & ~Status.EXL.
//     Combinational on registered state.
//   Reset mid-operation overrides any bus activity in the same cycle. All registers take
//     their reset values.
// TESTING
//   1 Reset, then read addr 12/13/14 -> rdata 32'h0040_0000 / 0 / 0; cp0_has_int=0.
//   2 mtc0 Status wdata=32'hFFFF_FFFF, then read -> 32'h0040_FF03; mtc0 Cause wdata=~0 -> 32'h0000_0300.
//   3 ex=1, excode=5'h04, bd=1, pc=32'hBFC0_0104, badvaddr=32'h0000_0003 ->
//     EPC=32'hBFC0_0100, Cause=32'h8000_0010, Status.EXL=1, BadVAddr=3.
//     A second ex with bd=0, pc=32'h1234 -> EPC unchanged.
//   4 eret in the same cycle as ex -> EXL stays 1. A later lone eret -> EXL=0.
//     ex with mtc0_we=1 addr 14 -> EPC takes the exception value, not wdata.
//   5 mtc0 Compare=10, Count=0; Status IM7=1, IE=1 -> Count reaches 10 after 20 clocks;
//     next cycle TI=1, IP7=1, cp0_has_int=1. mtc0 Compare -> TI=0, has_int=0.
//   6 ext_int_in=6'b000001 with IM2=1, IE=1, EXL=0 -> has_int=1 one cycle later.
//     Set EXL via ex -> has_int=0.

Source files
------------

// File: rtl/cp0_regfile_if.sv
// Write-back-to-CP0 bus plus the CP0 results returned to the pipeline.
//
// Bus semantics: there is no valid/ready handshake. wb_to_cp0_bus is sampled
// on every rising clk edge, and each of its command bits (ex, eret, mtc0_we)
// acts for exactly that one cycle. cp0_rdata, cp0_epc, ex_entry_pc and
// cp0_has_int are always valid. They are derived combinationally from
// registered CP0 state and the bus addr field.
interface cp0_regfile_if;
   logic [109:0] wb_to_cp0_bus;
   logic [31:0]  cp0_rdata;
   logic [31:0]  cp0_epc;
   logic [31:0]  ex_entry_pc;
   logic         cp0_has_int;

   // Write-back stage side
   modport master (
      output wb_to_cp0_bus,
      input  cp0_rdata,
      input  cp0_epc,
      input  ex_entry_pc,
      input  cp0_has_int
   );

   // CP0 register file side
   modport slave (
      input  wb_to_cp0_bus,
      output cp0_rdata,
      output cp0_epc,
      output ex_entry_pc,
      output cp0_has_int
   );
endinterface

// File: rtl/cp0_regfile.sv
// CP0 register file: BadVAddr, Count, Compare, Status, Cause, EPC (sel 0).
// Records exceptions, eret and mtc0 from WB. Runs the Count/Compare timer and
// flags enabled pending interrupts.
module cp0_regfile #(
   parameter logic [31:0] EX_ENTRY = 32'hBFC0_0380
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  ext_int_in,
   cp0_regfile_if.slave cp0
);

   // Bus field decode
   logic        bus_ex;
   logic [4:0]  bus_excode;
   logic [31:0] bus_badvaddr;
   logic        bus_bd;
   logic [31:0] bus_pc;
   logic        bus_mtc0_we;
   logic [4:0]  bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_eret;

   assign {bus_ex, bus_excode, bus_badvaddr, bus_bd, bus_pc,
           bus_mtc0_we, bus_addr, bus_wdata, bus_eret} = cp0.wb_to_cp0_bus;

   // Register state. Only the implemented bits of Status/Cause are stored.
   logic [31:0] badvaddr_r, count_r, compare_r, epc_r;
   logic        tick_r;
   logic [7:0]  im_r;
   logic        exl_r, ie_r;
   logic        bd_r, ti_r;
   logic [5:0]  ip_hw_r;
   logic [1:0]  ip_sw_r;
   logic [4:0]  excode_r;

   // An exception beats eret, and eret beats mtc0.
   logic wr_en;
   logic wr_count, wr_compare, wr_status, wr_cause, wr_epc;

   assign wr_en      = bus_mtc0_we & ~bus_ex & ~bus_eret;
   assign wr_count   = wr_en && (bus_addr == 5'd9);
   assign wr_compare = wr_en && (bus_addr == 5'd11);
   assign wr_status  = wr_en && (bus_addr == 5'd12);
   assign wr_cause   = wr_en && (bus_addr == 5'd13);
   assign wr_epc     = wr_en && (bus_addr == 5'd14);

   logic [31:0] status_val, cause_val;
   assign status_val = {9'b0, 1'b1, 6'b0, im_r, 6'b0, exl_r, ie_r};
   assign cause_val  = {bd_r, ti_r, 14'b0, ip_hw_r, ip_sw_r, 1'b0, excode_r, 2'b0};

   // Count advances once per two clocks. A Count write reloads it and realigns the tick.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_r <= 32'd0;
         tick_r  <= 1'b0;
      end else if (wr_count) begin
         count_r <= bus_wdata;
         tick_r  <= 1'b0;
      end else begin
         tick_r <= ~tick_r;
         if (tick_r) count_r <= count_r + 32'd1;
      end
   end

   // Compare register, written only by mtc0
   always_ff @(posedge clk) begin
      if (reset)           compare_r <= 32'd0;
      else if (wr_compare) compare_r <= bus_wdata;
   end

   // Timer interrupt: set on Count==Compare, held until a Compare write (which wins)
   always_ff @(posedge clk) begin
      if (reset)                      ti_r <= 1'b0;
      else if (wr_compare)            ti_r <= 1'b0;
      else if (count_r == compare_r)  ti_r <= 1'b1;
   end

   // Hardware interrupt pending bits track the lines; IP7 also carries the timer
   always_ff @(posedge clk) begin
      if (reset) ip_hw_r <= 6'd0;
      else       ip_hw_r <= {ext_int_in[5] | ti_r, ext_int_in[4:0]};
   end

   // Status: an exception sets EXL, eret clears it, mtc0 writes IM/EXL/IE
   always_ff @(posedge clk) begin
      if (reset) begin
         im_r  <= 8'd0;
         exl_r <= 1'b0;
         ie_r  <= 1'b0;
      end else if (bus_ex) begin
         exl_r <= 1'b1;
      end else if (bus_eret) begin
         exl_r <= 1'b0;
      end else if (wr_status) begin
         im_r  <= bus_wdata[15:8];
         exl_r <= bus_wdata[1];
         ie_r  <= bus_wdata[0];
      end
   end

   // Cause: exception code and BD come from the exception; only IP[9:8] is software-writable
   always_ff @(posedge clk) begin
      if (reset) begin
         bd_r     <= 1'b0;
         excode_r <= 5'd0;
         ip_sw_r  <= 2'd0;
      end else if (bus_ex) begin
         excode_r <= bus_excode;
         if (!exl_r) bd_r <= bus_bd;
      end else if (wr_cause) begin
         ip_sw_r <= bus_wdata[9:8];
      end
   end

   // EPC: captured on the first exception (not nested under EXL), or written by mtc0
   always_ff @(posedge clk) begin
      if (reset)                 epc_r <= 32'd0;
      else if (bus_ex && !exl_r) epc_r <= bus_bd ? (bus_pc - 32'd4) : bus_pc;
      else if (wr_epc)           epc_r <= bus_wdata;
   end

   // BadVAddr: captured only on address-error exceptions (AdEL/AdES)
   always_ff @(posedge clk) begin
      if (reset)
         badvaddr_r <= 32'd0;
      else if (bus_ex && ((bus_excode == 5'h04) || (bus_excode == 5'h05)))
         badvaddr_r <= bus_badvaddr;
   end

   // mfc0 read mux on current state; a same-cycle mtc0 is not bypassed
   always_comb begin
      cp0.cp0_rdata = 32'd0;
      case (bus_addr)
         5'd8:    cp0.cp0_rdata = badvaddr_r;
         5'd9:    cp0.cp0_rdata = count_r;
         5'd11:   cp0.cp0_rdata = compare_r;
         5'd12:   cp0.cp0_rdata = status_val;
         5'd13:   cp0.cp0_rdata = cause_val;
         5'd14:   cp0.cp0_rdata = epc_r;
         default: cp0.cp0_rdata = 32'd0;
      endcase
   end

   assign cp0.cp0_epc     = epc_r;
   assign cp0.ex_entry_pc = EX_ENTRY;
   assign cp0.cp0_has_int = (|({ip_hw_r, ip_sw_r} & im_r)) & ie_r & ~exl_r;

endmodule

// File: tb/tb_cp0_regfile.sv
// Testbench for cp0_regfile. Directed scenarios are followed by a random phase.
// Every cycle is checked against a register-level reference model.
module tb_cp0_regfile;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] ext_int_in = 6'd0;

   always #5 clk = ~clk;

   cp0_regfile_if bus_if ();

   cp0_regfile #(.EX_ENTRY(32'hBFC0_0380)) dut (
      .clk        (clk),
      .reset      (reset),
      .ext_int_in (ext_int_in),
      .cp0        (bus_if.slave)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, required finish before time limit");
      $fatal(1);
   end

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Full 32-bit architectural register images, updated from the rules cycle by cycle.
   logic [31:0] m_status, m_cause, m_epc, m_badv, m_count, m_compare;
   logic        m_tick;
   logic [109:0] cur_bus;
   logic [5:0]   cur_ext;
   logic         cur_rst;

   localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
   localparam logic [31:0] STATUS_RST   = 32'h0040_0000;

   function automatic logic [31:0] m_read(input logic [4:0] a);
      case (a)
         5'd8:    return m_badv;
         5'd9:    return m_count;
         5'd11:   return m_compare;
         5'd12:   return m_status;
         5'd13:   return m_cause;
         5'd14:   return m_epc;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic m_has_int();
      return (|(m_cause[15:8] & m_status[15:8])) && m_status[0] && !m_status[1];
   endfunction

   task automatic m_step();
      logic [31:0] n_status, n_cause, n_epc, n_badv, n_count, n_compare;
      logic        n_tick;
      logic        ex, bd, we, eret;
      logic [4:0]  excode, addr;
      logic [31:0] badv, pc, wd;
      {ex, excode, badv, bd, pc, we, addr, wd, eret} = cur_bus;
      if (cur_rst) begin
         m_status = STATUS_RST; m_cause = 0; m_epc = 0; m_badv = 0;
         m_count = 0; m_compare = 0; m_tick = 0;
         return;
      end
      n_status = m_status; n_cause = m_cause; n_epc = m_epc; n_badv = m_badv;
      n_compare = m_compare;
      n_tick = ~m_tick;
      n_count = m_tick ? m_count + 1 : m_count;
      if (m_count == m_compare) n_cause[30] = 1'b1;
      n_cause[15:10] = cur_ext;
      n_cause[15] = cur_ext[5] | m_cause[30];
      if (ex) begin
         n_status[1] = 1'b1;
         n_cause[6:2] = excode;
         if (!m_status[1]) begin
            n_epc = bd ? pc - 4 : pc;
            n_cause[31] = bd;
         end
         if (excode == 5'h04 || excode == 5'h05) n_badv = badv;
      end else if (eret) begin
         n_status[1] = 1'b0;
      end else if (we) begin
         case (addr)
            5'd9:  begin n_count = wd; n_tick = 1'b0; end
            5'd11: begin n_compare = wd; n_cause[30] = 1'b0; end
            5'd12: n_status = (wd & STATUS_WMASK) | STATUS_RST;
            5'd13: n_cause[9:8] = wd[9:8];
            5'd14: n_epc = wd;
            default: ;
         endcase
      end
      m_status = n_status; m_cause = n_cause; m_epc = n_epc; m_badv = n_badv;
      m_count = n_count; m_compare = n_compare; m_tick = n_tick;
   endtask

   // ---------------- driver tasks ----------------
   function automatic logic [109:0] mk_bus(input logic ex, input logic [4:0] excode,
         input logic [31:0] badv, input logic bd, input logic [31:0] pc, input logic we,
         input logic [4:0] addr, input logic [31:0] wdata, input logic eret);
      return {ex, excode, badv, bd, pc, we, addr, wdata, eret};
   endfunction

   function automatic logic [109:0] idle(input logic [4:0] addr);
      return mk_bus(0, 0, 0, 0, 0, 0, addr, 0, 0);
   endfunction

   function automatic logic [109:0] wr(input logic [4:0] addr, input logic [31:0] d);
      return mk_bus(0, 0, 0, 0, 0, 1, addr, d, 0);
   endfunction

   // Drive inputs, then check all outputs against the model at the falling edge
   task automatic apply(input logic [109:0] b, input logic [5:0] e, input logic r);
      bus_if.wb_to_cp0_bus = b;
      ext_int_in = e;
      reset = r;
      cur_bus = b; cur_ext = e; cur_rst = r;
      @(negedge clk);
      if (!r) begin
         chk("model_rdata", bus_if.cp0_rdata, m_read(b[37:33]));
         chk("model_epc", bus_if.cp0_epc, m_epc);
         chk("entry_pc", bus_if.ex_entry_pc, 32'hBFC0_0380);
         chk("model_has_int", {31'b0, bus_if.cp0_has_int}, {31'b0, m_has_int()});
      end
   endtask

   task automatic commit();
      @(posedge clk);
      m_step();
      #1;
   endtask

   task automatic step(input logic [109:0] b, input logic [5:0] e, input logic r);
      apply(b, e, r);
      commit();
   endtask

   task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
      apply(idle(a), 6'd0, 1'b0);
      chk(tag, bus_if.cp0_rdata, exp);
      commit();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [109:0] b;
      logic [5:0]   e;
      logic         r, ex, eret, we, bd;
      logic [4:0]   addr, excode;
      logic [31:0]  wd;
      int           sel;

      bus_if.wb_to_cp0_bus = '0;
      step(idle(0), 6'd0, 1'b1);
      step(idle(0), 6'd0, 1'b1);

      // Reset state
      apply(idle(13), 6'd0, 1'b0);
      chk("t1_cause", bus_if.cp0_rdata, 32'h0);
      chk("t1_has_int", {31'b0, bus_if.cp0_has_int}, 32'h0);
      commit();
      rd(12, 32'h0040_0000, "t1_status");
      rd(14, 32'h0, "t1_epc");

      // Writable masks of Status and Cause
      step(wr(11, 32'hFFFF_0000), 6'd0, 1'b0);
      step(wr(12, 32'hFFFF_FFFF), 6'd0, 1'b0);
      rd(12, 32'h0040_FF03, "t2_status_mask");
      step(wr(13, 32'hFFFF_FFFF), 6'd0, 1'b0);
      rd(13, 32'h0000_0300, "t2_cause_mask");

      // Exception in a delay slot, then a nested one
      step(wr(12, 32'h0), 6'd0, 1'b0);
      step(wr(13, 32'h0), 6'd0, 1'b0);
      step(mk_bus(1, 5'h04, 32'h3, 1, 32'hBFC0_0104, 0, 0, 0, 0), 6'd0, 1'b0);
      rd(14, 32'hBFC0_0100, "t3_epc");
      rd(13, 32'h8000_0010, "t3_cause");
      rd(12, 32'h0040_0002, "t3_status_exl");
      rd(8, 32'h0000_0003, "t3_badvaddr");
      step(mk_bus(1, 5'h0A, 32'hAAAA, 0, 32'h1234, 0, 0, 0, 0), 6'd0, 1'b0);
      rd(14, 32'hBFC0_0100, "t3_epc_nested");
      rd(8, 32'h0000_0003, "t3_badvaddr_kept");

      // Priority of ex over eret and mtc0
      step(mk_bus(1, 5'h0A, 0, 0, 32'h5678, 0, 0, 0, 1), 6'd0, 1'b0);
      rd(12, 32'h0040_0002, "t4_ex_beats_eret");
      step(mk_bus(0, 0, 0, 0, 0, 0, 0, 0, 1), 6'd0, 1'b0);
      rd(12, 32'h0040_0000, "t4_eret");
      step(mk_bus(1, 5'h0C, 0, 0, 32'h2000, 1, 14, 32'hDEAD_BEEF, 0), 6'd0, 1'b0);
      rd(14, 32'h0000_2000, "t4_ex_beats_mtc0");
      rd(13, 32'h0000_0030, "t4_cause");
      step(mk_bus(0, 0, 0, 0, 0, 0, 0, 0, 1), 6'd0, 1'b0);

      // Timer interrupt
      step(wr(12, 32'h0000_8001), 6'd0, 1'b0);
      step(wr(9, 32'h0), 6'd0, 1'b0);
      step(wr(11, 32'd10), 6'd0, 1'b0);
      repeat (19) step(idle(9), 6'd0, 1'b0);
      rd(9, 32'd10, "t5_count");
      apply(idle(13), 6'd0, 1'b0);
      chk("t5_ti_set", bus_if.cp0_rdata & 32'h4000_0000, 32'h4000_0000);
      commit();
      apply(idle(13), 6'd0, 1'b0);
      chk("t5_ip7", bus_if.cp0_rdata & 32'h0000_8000, 32'h0000_8000);
      chk("t5_has_int", {31'b0, bus_if.cp0_has_int}, 32'h1);
      commit();
      step(wr(11, 32'h0000_1000), 6'd0, 1'b0);
      apply(idle(13), 6'd0, 1'b0);
      chk("t5_ti_clear", bus_if.cp0_rdata & 32'h4000_0000, 32'h0);
      commit();
      apply(idle(13), 6'd0, 1'b0);
      chk("t5_has_int_clear", {31'b0, bus_if.cp0_has_int}, 32'h0);
      commit();

      // External interrupt, masked by EXL
      step(wr(12, 32'h0000_0401), 6'd0, 1'b0);
      step(idle(0), 6'd1, 1'b0);
      apply(idle(13), 6'd1, 1'b0);
      chk("t6_has_int", {31'b0, bus_if.cp0_has_int}, 32'h1);
      commit();
      step(mk_bus(1, 5'h00, 0, 0, 32'h3000, 0, 0, 0, 0), 6'd1, 1'b0);
      apply(idle(12), 6'd1, 1'b0);
      chk("t6_exl_masks", {31'b0, bus_if.cp0_has_int}, 32'h0);
      commit();

      // Reset overrides same-cycle bus activity
      step(wr(14, 32'h5555_0000), 6'd0, 1'b0);
      step(mk_bus(1, 5'h04, 32'hFFFF, 1, 32'h4000, 1, 14, 32'h1, 0), 6'h3F, 1'b1);
      rd(14, 32'h0, "rst_epc");
      rd(12, 32'h0040_0000, "rst_status");
      rd(8, 32'h0, "rst_badvaddr");

      // Random phase
      for (int i = 0; i < 3000; i++) begin
         ex   = ($urandom_range(0, 99) < 6);
         eret = ($urandom_range(0, 99) < 8);
         we   = ($urandom_range(0, 2) == 0);
         sel  = $urandom_range(0, 6);
         case (sel)
            0: addr = 5'd8;
            1: addr = 5'd9;
            2: addr = 5'd11;
            3: addr = 5'd12;
            4: addr = 5'd13;
            5: addr = 5'd14;
            default: addr = 5'($urandom_range(0, 31));
         endcase
         if (we && addr == 5'd8) we = 1'b0;
         wd = (addr == 5'd9 || addr == 5'd11) ? 32'($urandom_range(0, 40)) : $urandom;
         excode = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(4, 5)) : 5'($urandom_range(0, 31));
         bd = 1'($urandom_range(0, 1));
         b = mk_bus(ex, excode, $urandom, bd, $urandom, we, addr, wd, eret);
         e = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
         r = ($urandom_range(0, 199) == 0);
         step(b, e, r);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
